// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Brief    : Owns the architectural PC; fetches words over req/ack and hands
//            each instruction to decode over valid/ready, applying redirects.
// Revision : 1.0
// ============================================================================
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redir_valid,
  input  logic [1:0]  redir_op,
  input  logic [25:0] redir_imm,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_jraddr,
  output logic        align_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam logic [1:0] OP_PLUS4  = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_JUMP   = 2'b10;
  localparam logic [1:0] OP_JR     = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        align_err_q, align_err_d;

  logic [31:0] p4;
  logic [31:0] target;

  always_comb begin
    p4 = redir_pc + 32'd4;
    case (redir_op)
      OP_PLUS4:  target = p4;
      OP_BRANCH: target = p4 + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
      OP_JUMP:   target = {p4[31:28], redir_imm, 2'b00};
      OP_JR:     target = {redir_jraddr[31:2], 2'b00};
      default:   target = p4;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack && !redir_valid) begin
          state_d = S_VALID;
        end else if (!imem_ack && redir_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end
      S_VALID: begin
        if (redir_valid || id_ready) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    imem_req = (state_q == S_FETCH) || (state_q == S_DROP);
    if_valid = (state_q == S_VALID);
  end

  assign imem_addr = pc_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign align_err = align_err_q;

  // A redirect arriving with a fetch outstanding must not move imem_addr, so
  // it is parked in pend until the memory acknowledges the stale request.
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack && !redir_valid) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
        end else if (imem_ack && redir_valid) begin
          pc_d = target;
        end else if (redir_valid) begin
          pend_d = target;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          pc_d = redir_valid ? target : pend_q;
        end else if (redir_valid) begin
          pend_d = target;
        end
      end
      S_VALID: begin
        if (redir_valid) begin
          pc_d = target;
        end else if (id_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end
      default: ;
    endcase
    align_err_d = align_err_q
                | ((state_q != S_IDLE) && redir_valid && (redir_op == OP_JR)
                   && (redir_jraddr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pend_q      <= 32'd0;
      if_instr_q  <= 32'd0;
      if_pc_q     <= 32'd0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      align_err_q <= align_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Brief    : Vector table, directed corner sequences and random run vs model.
// Revision : 1.0
// ============================================================================
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_op = 2'b00;
  logic [25:0] redir_imm = 26'd0;
  logic [31:0] redir_pc = 32'd0;
  logic [31:0] redir_jraddr = 32'd0;
  logic        align_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready),
    .redir_valid(redir_valid), .redir_op(redir_op), .redir_imm(redir_imm),
    .redir_pc(redir_pc), .redir_jraddr(redir_jraddr),
    .align_err(align_err)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [1:0]  op;
    logic [25:0] imm;
    logic [31:0] rpc;
    logic [31:0] jr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic        e_err;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic redir, input logic [1:0] op, input logic [25:0] imm,
                              input logic [31:0] rpc, input logic [31:0] jr,
                              input logic e_req, input logic e_valid, input logic [31:0] e_addr,
                              input logic [31:0] e_ipc, input logic [31:0] e_instr,
                              input logic e_err);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.op = op;
    v.imm = imm; v.rpc = rpc; v.jr = jr; v.e_req = e_req; v.e_valid = e_valid;
    v.e_addr = e_addr; v.e_ipc = e_ipc; v.e_instr = e_instr; v.e_err = e_err;
    return v;
  endfunction

  // Behavioural model: a fetch is either outstanding (possibly to be thrown
  // away) or an instruction is held; nothing happens before the first clock.
  logic        m_started, m_out, m_disc, m_held, m_err;
  logic [31:0] m_pc, m_pend, m_instr, m_ipc;

  function automatic logic [31:0] ref_target();
    logic [31:0] off;
    off = 32'($signed(redir_imm[15:0]));
    case (redir_op)
      2'd0:    return redir_pc + 32'd4;
      2'd1:    return redir_pc + 32'd4 + off * 32'd4;
      2'd2:    return ((redir_pc + 32'd4) & 32'hF000_0000) + 32'(redir_imm) * 32'd4;
      default: return redir_jraddr & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_reset();
    m_started = 0; m_out = 0; m_disc = 0; m_held = 0; m_err = 0;
    m_pc = 32'h0000_3000; m_pend = 0; m_instr = 0; m_ipc = 0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    t = ref_target();
    if (!m_started) begin
      m_started = 1; m_out = 1;
    end else begin
      if (redir_valid && redir_op == 2'd3 && redir_jraddr[1:0] != 0) m_err = 1;
      if (m_out) begin
        if (imem_ack) begin
          if (m_disc) begin
            m_pc = redir_valid ? t : m_pend; m_disc = 0;
          end else if (redir_valid) begin
            m_pc = t;
          end else begin
            m_held = 1; m_out = 0; m_instr = imem_rdata; m_ipc = m_pc;
          end
        end else if (redir_valid) begin
          m_pend = t; m_disc = 1;
        end
      end else if (m_held) begin
        if (redir_valid) begin
          m_held = 0; m_out = 1; m_pc = t;
        end else if (id_ready) begin
          m_held = 0; m_out = 1; m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    vectors++;
    if (imem_req !== m_out || if_valid !== m_held || imem_addr !== m_pc ||
        if_instr !== m_instr || if_pc !== m_ipc || align_err !== m_err ||
        (imem_req && if_valid)) begin
      miscompares++;
      $display("FAIL %s: got req=%b valid=%b addr=%h instr=%h ipc=%h err=%b, want req=%b valid=%b addr=%h instr=%h ipc=%h err=%b",
               name, imem_req, if_valid, imem_addr, if_instr, if_pc, align_err,
               m_out, m_held, m_pc, m_instr, m_ipc, m_err);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 0; imem_rdata = 0; id_ready = 0; redir_valid = 0;
    redir_op = 0; redir_imm = 0; redir_pc = 0; redir_jraddr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
    end
    rst = 0;
    model_reset();
  endtask

  initial begin
    // ack, rdata, ready, redir, op, imm, rpc, jr | req, valid, addr, ipc, instr, err
    tbl[0]  = mk(1, 32'h0, 0, 1, 2'd3, 26'h0,    32'h0,    32'h4002, 0, 0, 32'h3000, 32'h0,    32'h0,    0);
    tbl[1]  = mk(1, 32'hA1, 0, 0, 2'd0, 26'h0,   32'h0,    32'h0,    1, 0, 32'h3000, 32'h0,    32'h0,    0);
    tbl[2]  = mk(0, 32'h0, 1, 0, 2'd0, 26'h0,    32'h0,    32'h0,    0, 1, 32'h3000, 32'h3000, 32'hA1,   0);
    tbl[3]  = mk(1, 32'hA2, 0, 0, 2'd0, 26'h0,   32'h0,    32'h0,    1, 0, 32'h3004, 32'h0,    32'h0,    0);
    tbl[4]  = mk(0, 32'h0, 1, 1, 2'd1, 26'hFFFE, 32'h3010, 32'h0,    0, 1, 32'h3004, 32'h3004, 32'hA2,   0);
    tbl[5]  = mk(1, 32'hA3, 0, 0, 2'd0, 26'h0,   32'h0,    32'h0,    1, 0, 32'h300C, 32'h0,    32'h0,    0);
    tbl[6]  = mk(0, 32'h0, 0, 1, 2'd2, 26'hC40,  32'h3000, 32'h0,    0, 1, 32'h300C, 32'h300C, 32'hA3,   0);
    tbl[7]  = mk(1, 32'hA4, 0, 0, 2'd0, 26'h0,   32'h0,    32'h0,    1, 0, 32'h3100, 32'h0,    32'h0,    0);
    tbl[8]  = mk(0, 32'h0, 0, 1, 2'd3, 26'h0,    32'h0,    32'h4002, 0, 1, 32'h3100, 32'h3100, 32'hA4,   0);
    tbl[9]  = mk(0, 32'h0, 0, 0, 2'd0, 26'h0,    32'h0,    32'h0,    1, 0, 32'h4000, 32'h0,    32'h0,    1);
    tbl[10] = mk(1, 32'hA5, 0, 0, 2'd0, 26'h0,   32'h0,    32'h0,    1, 0, 32'h4000, 32'h0,    32'h0,    1);
    tbl[11] = mk(0, 32'h0, 0, 0, 2'd0, 26'h0,    32'h0,    32'h0,    0, 1, 32'h4000, 32'h4000, 32'hA5,   1);
    tbl[12] = mk(0, 32'h0, 1, 0, 2'd0, 26'h0,    32'h0,    32'h0,    0, 1, 32'h4000, 32'h4000, 32'hA5,   1);
    tbl[13] = mk(1, 32'hA6, 0, 1, 2'd0, 26'h0,   32'h5000, 32'h0,    1, 0, 32'h4004, 32'h0,    32'h0,    1);
    tbl[14] = mk(1, 32'hA7, 0, 0, 2'd0, 26'h0,   32'h0,    32'h0,    1, 0, 32'h5004, 32'h0,    32'h0,    1);
    tbl[15] = mk(0, 32'h0, 0, 0, 2'd0, 26'h0,    32'h0,    32'h0,    0, 1, 32'h5004, 32'h5004, 32'hA7,   1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata; id_ready = tbl[i].ready;
      redir_valid = tbl[i].redir; redir_op = tbl[i].op; redir_imm = tbl[i].imm;
      redir_pc = tbl[i].rpc; redir_jraddr = tbl[i].jr;
      vectors++;
      if (imem_req !== tbl[i].e_req || if_valid !== tbl[i].e_valid ||
          imem_addr !== tbl[i].e_addr || align_err !== tbl[i].e_err ||
          (tbl[i].e_valid && (if_pc !== tbl[i].e_ipc || if_instr !== tbl[i].e_instr))) begin
        miscompares++;
        $display("FAIL table[%0d]: got req=%b valid=%b addr=%h ipc=%h instr=%h err=%b, want req=%b valid=%b addr=%h ipc=%h instr=%h err=%b",
                 i, imem_req, if_valid, imem_addr, if_pc, if_instr, align_err,
                 tbl[i].e_req, tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_ipc,
                 tbl[i].e_instr, tbl[i].e_err);
      end
      tick();
    end

    // Wait states: three fetches, each acknowledged after three idle cycles
    do_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      for (int w = 0; w < 3; w++) begin
        chk("ws_req", {31'd0, imem_req}, 32'd1);
        chk("ws_addr", imem_addr, 32'h3000 + 32'(k) * 4);
        tick();
      end
      imem_ack = 1; imem_rdata = 32'hBEEF_0000 + 32'(k);
      tick();
      imem_ack = 0; id_ready = 1;
      chk("ws_valid", {31'd0, if_valid}, 32'd1);
      chk("ws_ipc", if_pc, 32'h3000 + 32'(k) * 4);
      chk("ws_instr", if_instr, 32'hBEEF_0000 + 32'(k));
      tick();
    end

    // Two redirects while a fetch is outstanding; the later one wins
    do_reset();
    tick();
    imem_ack = 1; imem_rdata = 32'h1111;
    tick();
    imem_ack = 0; id_ready = 1;
    tick();
    id_ready = 0;
    redir_valid = 1; redir_op = 2'd2; redir_pc = 32'h3000; redir_imm = 26'hC80;
    chk("drop_addr0", imem_addr, 32'h3004);
    tick();
    redir_imm = 26'hCC0;
    chk("drop_addr1", imem_addr, 32'h3004);
    chk("drop_req1", {31'd0, imem_req}, 32'd1);
    tick();
    redir_valid = 0; imem_ack = 1; imem_rdata = 32'hDEAD_DEAD;
    chk("drop_addr2", imem_addr, 32'h3004);
    tick();
    imem_ack = 0;
    chk("drop_novalid", {31'd0, if_valid}, 32'd0);
    chk("drop_addr3", imem_addr, 32'h3300);
    chk("drop_req3", {31'd0, imem_req}, 32'd1);

    // Decode stall for five cycles
    do_reset();
    tick();
    imem_ack = 1; imem_rdata = 32'h5A5A_5A5A;
    tick();
    imem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_instr", if_instr, 32'h5A5A_5A5A);
      chk("stall_ipc", if_pc, 32'h3000);
      tick();
    end
    id_ready = 1;
    tick();
    id_ready = 0;
    chk("stall_addr", imem_addr, 32'h3004);

    // PC wraps from the top word to zero
    do_reset();
    tick();
    imem_ack = 1; redir_valid = 1; redir_op = 2'd3; redir_jraddr = 32'hFFFF_FFFC;
    tick();
    redir_valid = 0; imem_rdata = 32'h7777;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_ack = 0; id_ready = 1;
    chk("wrap_ipc", if_pc, 32'hFFFF_FFFC);
    tick();
    id_ready = 0;
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_err", {31'd0, align_err}, 32'd0);

    // Asynchronous reset in the middle of a fetch
    do_reset();
    tick();
    imem_ack = 1; imem_rdata = 32'h9999;
    tick();
    imem_ack = 0; id_ready = 1;
    tick();
    id_ready = 0;
    #3 rst = 1;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h3000);
    chk("arst_ipc", if_pc, 32'h0);
    chk("arst_instr", if_instr, 32'h0);
    imem_ack = 1;
    tick();
    rst = 0;
    chk("arst_idle", {31'd0, imem_req}, 32'd0);
    tick();
    chk("arst_fetch", {31'd0, imem_req}, 32'd1);
    chk("arst_faddr", imem_addr, 32'h3000);

    // Random traffic against the behavioural model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      imem_ack = ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom;
      id_ready = ($urandom_range(0, 1) == 1);
      redir_valid = ($urandom_range(0, 3) == 0);
      redir_op = 2'($urandom_range(0, 3));
      redir_imm = 26'($urandom);
      redir_pc = $urandom & 32'hFFFF_FFFC;
      redir_jraddr = $urandom;
      if ($urandom_range(0, 7) != 0) redir_jraddr[1:0] = 2'b00;
      check_model("random");
      model_step();
      tick();
    end
    clear_inputs();
    check_model("random_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
